// File: rtl/romulus_pkg.sv
// Shared constants for the Romulus-N PDI input path, used by the host wrapper
// and by pdi_fifo so both sides agree on word width, depth and pacing threshold.
package romulus_pkg;

    localparam int unsigned PDI_WIDTH      = 32;
    localparam int unsigned PDI_FIFO_DEPTH = 8;
    localparam int unsigned PDI_AFULL_TH   = 6;

    // Pointer width for a power-of-two FIFO depth (depth >= 2)
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on clk.
module rst_sync (
    input  logic clk,
    input  logic arst_n,
    output logic srst_n
);

    logic [1:0] sync;

    // Shift a one in after arst_n releases; clear immediately when it asserts
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    assign srst_n = sync[1];

endmodule

// File: rtl/pdi_fifo.sv
// First-word-fall-through elastic buffer in front of the core's PDI port.
// Optional synchronous flush input enabled by defining PDI_FIFO_FLUSH_EN.
module pdi_fifo
    import romulus_pkg::*;
#(
    parameter int unsigned WIDTH    = PDI_WIDTH,
    parameter int unsigned DEPTH    = PDI_FIFO_DEPTH,
    parameter int unsigned AFULL_TH = PDI_AFULL_TH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           pdi_data,
    output logic                       pdi_valid,
    input  logic                       pdi_ready,
`ifdef PDI_FIFO_FLUSH_EN
    input  logic                       flush,
`endif
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full
);

    localparam int unsigned PW = fifo_ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic             rst_n_int;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             clr;
    logic             push;
    logic             pop;

    // Internal reset: follows rst low at once, releases two clocks after rst rises
    rst_sync u_rst_sync (
        .clk    (clk),
        .arst_n (rst),
        .srst_n (rst_n_int)
    );

`ifdef PDI_FIFO_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign full = (count == CW'(DEPTH));

    // s_ready reads 1 while rst is held low and 0 during the release window;
    // flush keeps it high so the host never sees back-pressure while abandoning
    assign s_ready = !rst || (rst_n_int && (!full || clr));

    // Handshakes from registered state; flush drops both sides of the cycle
    assign push = s_valid && rst_n_int && !full && !clr;
    assign pop  = pdi_valid && pdi_ready && !clr;

    assign pdi_valid   = (count != '0);
    assign pdi_data    = mem[rd_ptr];
    assign level       = count;
    assign almost_full = (count >= CW'(AFULL_TH));

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents survive reset and are only meaningful when valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

endmodule

// File: tb/tb_pdi_fifo.sv
// Scoreboard bench for pdi_fifo: the driver queues every accepted word, a
// separate monitor pops and compares on each core-side handshake.
module tb_pdi_fifo;

    localparam int unsigned W  = 32;
    localparam int unsigned LW = 4;

    logic          clk;
    logic          rst;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  pdi_data;
    logic          pdi_valid;
    logic          pdi_ready;
    logic [LW-1:0] level;
    logic          almost_full;
`ifdef PDI_FIFO_FLUSH_EN
    logic          flush;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q [$];

    pdi_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .pdi_data    (pdi_data),
        .pdi_valid   (pdi_valid),
        .pdi_ready   (pdi_ready),
`ifdef PDI_FIFO_FLUSH_EN
        .flush       (flush),
`endif
        .level       (level),
        .almost_full (almost_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    // One cycle: drive inputs after the falling edge, record the word if accepted
    task automatic cyc(input logic sv, input logic [W-1:0] sd, input logic pr,
                       input logic fl, output logic pushed);
        @(negedge clk);
        #1;
        s_valid   = sv;
        s_data    = sd;
        pdi_ready = pr;
`ifdef PDI_FIFO_FLUSH_EN
        flush     = fl;
`endif
        #1;
        pushed = s_valid && s_ready && rst && !fl;
        if (pushed) exp_q.push_back(sd);
        if (fl) exp_q.delete();
    endtask

    task automatic drv(input logic sv, input logic [W-1:0] sd, input logic pr);
        logic p;
        cyc(sv, sd, pr, 1'b0, p);
    endtask

    // Assert rst mid-cycle, check reset outputs, then walk through the release
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_pdi_valid",   32'(pdi_valid),   32'd0);
        check("rst_level",       32'(level),       32'd0);
        check("rst_s_ready",     32'(s_ready),     32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("release_s_ready_low", 32'(s_ready), 32'd0);
        repeat (3) drv(1'b0, '0, 1'b0);
        check("release_s_ready_high", 32'(s_ready), 32'd1);
    endtask

    // Monitor: compares popped words in order and data stability under stall
    initial begin : monitor
        logic         prev_stall;
        logic [W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && pdi_valid) check("stall_stable", pdi_data, prev_data);
                if (pdi_valid && pdi_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL pop_unexpected: got 0x%0h, want no word", pdi_data);
                    end else begin
                        check("pop_order", pdi_data, exp_q.pop_front());
                    end
                end
                prev_stall = pdi_valid && !pdi_ready;
                prev_data  = pdi_data;
            end
        end
    end

    initial begin : stim
        logic p;
        int   idx;
        int   ncyc;
        bit   drained;

        rst       = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        pdi_ready = 1'b0;
`ifdef PDI_FIFO_FLUSH_EN
        flush     = 1'b0;
`endif
        do_reset();

        // Reset mid-burst: buffered words must vanish
        for (int i = 1; i <= 5; i++) drv(1'b1, 32'hA000_0000 + W'(i), 1'b0);
        drv(1'b0, '0, 1'b0);
        check("burst_level", 32'(level), 32'd5);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, '0, 1'b1);
            check("post_rst_pdi_valid", 32'(pdi_valid), 32'd0);
        end

        // Single-word latency, no same-cycle bypass
        drv(1'b1, 32'h1234_5678, 1'b0);
        check("lat_no_bypass", 32'(pdi_valid), 32'd0);
        drv(1'b0, '0, 1'b1);
        check("lat_valid", 32'(pdi_valid), 32'd1);
        check("lat_data",  pdi_data, 32'h1234_5678);
        check("lat_level", 32'(level), 32'd1);
        drv(1'b0, '0, 1'b0);
        check("lat_level_after_pop", 32'(level), 32'd0);
        check("lat_valid_after_pop", 32'(pdi_valid), 32'd0);

        // Fill to full with the core stalled
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, W'(i), 1'b0);
            check("fill_level", 32'(level), 32'(i));
            check("fill_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, p);
        check("full_level",   32'(level), 32'd8);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_afull",   32'(almost_full), 32'd1);
        check("full_no_push", 32'(p), 32'd0);
        drv(1'b0, '0, 1'b0);
        check("full_hold_level", 32'(level), 32'd8);

        // Full with simultaneous pop and push: push waits a cycle
        cyc(1'b1, 32'h8, 1'b1, 1'b0, p);
        check("fullpp_s_ready", 32'(s_ready), 32'd0);
        check("fullpp_no_push", 32'(p), 32'd0);
        cyc(1'b1, 32'h8, 1'b0, 1'b0, p);
        check("fullpp_level7",  32'(level), 32'd7);
        check("fullpp_push",    32'(p), 32'd1);
        drv(1'b0, '0, 1'b0);
        check("fullpp_level8",  32'(level), 32'd8);
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            drv(1'b0, '0, 1'b1);
            if (!pdi_valid) drained = 1'b1;
        end
        check("drain_done",  32'(drained), 32'd1);
        check("drain_level", 32'(level), 32'd0);

        // Wrap and ordering under random handshakes
        idx  = 0;
        ncyc = 0;
        while ((idx < 20 || exp_q.size() != 0) && ncyc < 400) begin
            cyc((idx < 20) ? 1'($urandom_range(0, 1)) : 1'b0, 32'h100 + W'(idx),
                1'($urandom_range(0, 1)), 1'b0, p);
            if (p) idx++;
            ncyc++;
        end
        check("wrap_pushed", 32'(idx), 32'd20);
        check("wrap_all_popped", 32'(exp_q.size()), 32'd0);
        drv(1'b0, '0, 1'b0);
        check("wrap_level", 32'(level), 32'd0);

`ifdef PDI_FIFO_FLUSH_EN
        // Flush with 5 words buffered and a simultaneous push
        for (int i = 0; i < 5; i++) drv(1'b1, 32'h200 + W'(i), 1'b0);
        cyc(1'b1, 32'h0000_BEEF, 1'b0, 1'b1, p);
        check("flush_level_before", 32'(level), 32'd5);
        check("flush_s_ready", 32'(s_ready), 32'd1);
        drv(1'b0, '0, 1'b0);
        check("flush_level", 32'(level), 32'd0);
        check("flush_pdi_valid", 32'(pdi_valid), 32'd0);
        drv(1'b1, 32'h300, 1'b0);
        drv(1'b0, '0, 1'b1);
        check("flush_next_data", pdi_data, 32'h300);
        drv(1'b0, '0, 1'b0);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
